// File: rtl/core_types_pkg.sv
// Shared core types for the store-set update path.
// Provides the ssu_update_t payload, the update-source count and the
// index constants naming each source, plus the default input buffer depth.
package core_types_pkg;

  localparam int unsigned MDPT_INFO_WIDTH          = 8;
  localparam int unsigned LOG_ROB_ENTRIES          = 7;
  localparam int unsigned SSU_UPDATE_REQUESTERS    = 6;
  localparam int unsigned SSU_INPUT_BUFFER_ENTRIES = 4;

  // Source index order seen by the update arbiter
  localparam int unsigned SSU_SRC_LDU_CQ_CAM        = 0;
  localparam int unsigned SSU_SRC_LDU_MQ_CAM        = 1;
  localparam int unsigned SSU_SRC_LDU_CQ_COMMIT     = 2;
  localparam int unsigned SSU_SRC_STAMOFU_CQ_CAM0   = 3;
  localparam int unsigned SSU_SRC_STAMOFU_CQ_CAM1   = 4;
  localparam int unsigned SSU_SRC_STAMOFU_CQ_COMMIT = 5;

  // Commit sources carry the committing op in ld_* with is_dep=0;
  // stamo_* is opaque pass-through for them.
  typedef struct packed {
    logic                       is_dep;
    logic [MDPT_INFO_WIDTH-1:0] ld_mdp_info;
    logic [LOG_ROB_ENTRIES-1:0] ld_ROB_index;
    logic [MDPT_INFO_WIDTH-1:0] stamo_mdp_info;
    logic [LOG_ROB_ENTRIES-1:0] stamo_ROB_index;
  } ssu_update_t;

endpackage

// File: rtl/ssu_update_fifo.sv
// Single-source update FIFO; caller gates enq_i so it never writes when
// full unless deq_i is asserted in the same cycle.
// Ports: CLK, nRST (async active-low), enq_i/enq_data_i write side,
// deq_i pop (only when non-empty), full_o/empty_o status, head_o oldest entry.
module ssu_update_fifo
  import core_types_pkg::*;
#(
  parameter int unsigned ENTRIES = SSU_INPUT_BUFFER_ENTRIES
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        enq_i,
  input  ssu_update_t enq_data_i,
  input  logic        deq_i,
  output logic        full_o,
  output logic        empty_o,
  output ssu_update_t head_o
);

  localparam int unsigned PTR_W = $clog2(ENTRIES);
  localparam int unsigned CNT_W = PTR_W + 1;

  ssu_update_t      mem_q [ENTRIES];
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer/count next state; pointers wrap naturally at a power-of-2 depth
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (enq_i) wptr_d = wptr_q + PTR_W'(1);
    if (deq_i) rptr_d = rptr_q + PTR_W'(1);
    case ({enq_i, deq_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an empty count masks stale contents
  always_ff @(posedge CLK) begin
    if (enq_i) mem_q[wptr_q] <= enq_data_i;
  end

  assign full_o  = (count_q == CNT_W'(ENTRIES));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/ssu_update_arbiter.sv
// Funnels the memory-dependence update sources into one registered
// valid/ready stream for the store-set table stage. Each source has a small
// FIFO; overflow is dropped and counted rather than back-pressured.
// Ports: CLK, nRST (async active-low); req_valid/req_update per source;
// out_valid/out_ready/out_update/out_src granted stream; drop_pulse per-source
// one-cycle drop flag; drop_count saturating total of dropped updates.
module ssu_update_arbiter
  import core_types_pkg::*;
#(
  parameter int unsigned REQUESTER_COUNT  = SSU_UPDATE_REQUESTERS,
  parameter int unsigned FIFO_ENTRIES     = SSU_INPUT_BUFFER_ENTRIES,
  parameter int unsigned DROP_COUNT_WIDTH = 16
) (
  input  logic                                 CLK,
  input  logic                                 nRST,
  input  logic [REQUESTER_COUNT-1:0]           req_valid,
  input  ssu_update_t [REQUESTER_COUNT-1:0]    req_update,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output ssu_update_t                          out_update,
  output logic [$clog2(REQUESTER_COUNT)-1:0]   out_src,
  output logic [REQUESTER_COUNT-1:0]           drop_pulse,
  output logic [DROP_COUNT_WIDTH-1:0]          drop_count
);

  localparam int unsigned SRC_W = $clog2(REQUESTER_COUNT);
  localparam int unsigned CNT_W = $clog2(REQUESTER_COUNT + 1);
  localparam int unsigned SUM_W = DROP_COUNT_WIDTH + 1;

  logic [REQUESTER_COUNT-1:0] fifo_full, fifo_empty;
  logic [REQUESTER_COUNT-1:0] enq, deq, drop;
  ssu_update_t                fifo_head [REQUESTER_COUNT];

  logic                        load, grant_found, grant;
  logic [SRC_W-1:0]            grant_idx;
  logic [CNT_W-1:0]            drop_num;
  logic [SUM_W-1:0]            drop_sum;

  logic                        out_valid_q, out_valid_d;
  ssu_update_t                 out_update_q, out_update_d;
  logic [SRC_W-1:0]            out_src_q, out_src_d;
  logic [SRC_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [REQUESTER_COUNT-1:0]  drop_pulse_q, drop_pulse_d;
  logic [DROP_COUNT_WIDTH-1:0] drop_count_q, drop_count_d;

  for (genvar g = 0; g < REQUESTER_COUNT; g++) begin : g_fifo
    ssu_update_fifo #(.ENTRIES(FIFO_ENTRIES)) u_fifo (
      .CLK        (CLK),
      .nRST       (nRST),
      .enq_i      (enq[g]),
      .enq_data_i (req_update[g]),
      .deq_i      (deq[g]),
      .full_o     (fifo_full[g]),
      .empty_o    (fifo_empty[g]),
      .head_o     (fifo_head[g])
    );
  end

  // Round-robin search over current heads, starting just after rr_ptr
  always_comb begin
    logic [SRC_W-1:0] cand;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 1; k <= REQUESTER_COUNT; k++) begin
      cand = SRC_W'((32'(rr_ptr_q) + k) % REQUESTER_COUNT);
      if (!grant_found && !fifo_empty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Pop/push/drop decisions; a full FIFO still accepts when popped this cycle
  always_comb begin
    load  = ~out_valid_q | out_ready;
    grant = load & grant_found;
    deq   = '0;
    if (grant) deq[grant_idx] = 1'b1;
    enq   = req_valid & (~fifo_full | deq);
    drop  = req_valid & ~enq;
  end

  // Output register, pointer and drop accounting next state
  always_comb begin
    out_valid_d  = out_valid_q;
    out_update_d = out_update_q;
    out_src_d    = out_src_q;
    rr_ptr_d     = rr_ptr_q;
    drop_pulse_d = drop;
    drop_num     = '0;
    for (int unsigned i = 0; i < REQUESTER_COUNT; i++) begin
      drop_num = drop_num + CNT_W'(drop[i]);
    end
    drop_sum     = SUM_W'(drop_count_q) + SUM_W'(drop_num);
    drop_count_d = drop_sum[DROP_COUNT_WIDTH] ? '1 : drop_sum[DROP_COUNT_WIDTH-1:0];
    if (load) begin
      out_valid_d = grant_found;
      if (grant_found) begin
        out_update_d = fifo_head[grant_idx];
        out_src_d    = grant_idx;
        rr_ptr_d     = grant_idx;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid_q  <= 1'b0;
      out_update_q <= '0;
      out_src_q    <= '0;
      rr_ptr_q     <= SRC_W'(REQUESTER_COUNT - 1);
      drop_pulse_q <= '0;
      drop_count_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_update_q <= out_update_d;
      out_src_q    <= out_src_d;
      rr_ptr_q     <= rr_ptr_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_update = out_update_q;
  assign out_src    = out_src_q;
  assign drop_pulse = drop_pulse_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_ssu_update_arbiter.sv
// Directed bench for ssu_update_arbiter: expected grants are queued when
// stimulus is driven and checked as each output handshake occurs.
module tb_ssu_update_arbiter;
  import core_types_pkg::*;

  localparam int unsigned N   = SSU_UPDATE_REQUESTERS;
  localparam int unsigned DCW = 16;

  logic                CLK = 1'b0;
  logic                nRST;
  logic [N-1:0]        req_valid;
  ssu_update_t [N-1:0] req_update;
  logic                out_valid;
  logic                out_ready;
  ssu_update_t         out_update;
  logic [2:0]          out_src;
  logic [N-1:0]        drop_pulse;
  logic [DCW-1:0]      drop_count;

  typedef struct packed {
    logic [2:0]  src;
    ssu_update_t upd;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   grants = 0;

  ssu_update_arbiter #(
    .REQUESTER_COUNT  (N),
    .FIFO_ENTRIES     (SSU_INPUT_BUFFER_ENTRIES),
    .DROP_COUNT_WIDTH (DCW)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .req_valid  (req_valid),
    .req_update (req_update),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_update (out_update),
    .out_src    (out_src),
    .drop_pulse (drop_pulse),
    .drop_count (drop_count)
  );

  always #5 CLK = ~CLK;

  function automatic ssu_update_t mk(int unsigned src, int unsigned seq);
    ssu_update_t u;
    u.is_dep          = (src != SSU_SRC_LDU_CQ_COMMIT) && (src != SSU_SRC_STAMOFU_CQ_COMMIT);
    u.ld_mdp_info     = MDPT_INFO_WIDTH'(src * 16 + seq + 1);
    u.ld_ROB_index    = LOG_ROB_ENTRIES'(seq * 5 + src * 11 + 3);
    u.stamo_mdp_info  = MDPT_INFO_WIDTH'(32'hA5 ^ (src << 4) ^ seq);
    u.stamo_ROB_index = LOG_ROB_ENTRIES'(src * 7 + seq * 13 + 1);
    return u;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(int unsigned s, ssu_update_t u);
    exp_t e;
    e.src = 3'(s);
    e.upd = u;
    sb.push_back(e);
  endtask

  // Handshake monitor: called mid-cycle, before the edge that completes it
  task automatic mon();
    exp_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      grants++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_unexpected_grant observed src=%0d expected none", out_src);
      end else begin
        e = sb.pop_front();
        chk("grant_src", 64'(out_src), 64'(e.src));
        chk("grant_payload", 64'(out_update), 64'(e.upd));
      end
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    mon();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(string tag, int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) cyc();
    chk(tag, 64'(sb.size()), 64'(0));
  endtask

  task automatic do_reset();
    req_valid = '0;
    out_ready = 1'b0;
    nRST      = 1'b0;
    #1;
    sb.delete();
    grants = 0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    nRST       = 1'b1;
    req_valid  = '0;
    req_update = '0;
    out_ready  = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    chk("rst_out_valid",  64'(out_valid),  64'(0));
    chk("rst_out_update", 64'(out_update), 64'(0));
    chk("rst_out_src",    64'(out_src),    64'(0));
    chk("rst_drop_pulse", 64'(drop_pulse), 64'(0));
    chk("rst_drop_count", 64'(drop_count), 64'(0));
    @(posedge CLK);
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // Single update on source 3: visible two cycles later, gone the next
    out_ready     = 1'b1;
    req_valid     = 6'b001000;
    req_update[3] = mk(3, 9);
    cyc();
    req_valid = '0;
    chk("t1_c1_valid", 64'(out_valid), 64'(0));
    push(3, mk(3, 9));
    cyc();
    chk("t1_c2_valid", 64'(out_valid), 64'(1));
    chk("t1_c2_src",   64'(out_src),   64'(3));
    cyc();
    chk("t1_c3_valid", 64'(out_valid), 64'(0));
    chk("t1_sb_empty", 64'(sb.size()), 64'(0));

    // All six sources every cycle for 20 cycles
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 43; k++) push(k % 6, mk(k % 6, 0));
    for (int c = 0; c < 20; c++) begin
      req_valid = '1;
      for (int i = 0; i < 6; i++) req_update[i] = mk(i, 0);
      cyc();
    end
    req_valid = '0;
    drain("t2_drained", 60);
    cyc();
    chk("t2_idle_valid", 64'(out_valid),  64'(0));
    chk("t2_grants",     64'(grants),     64'(43));
    chk("t2_drop_count", 64'(drop_count), 64'(77));

    // Source 1 back-to-back with output stalled: sixth update dropped
    do_reset();
    out_ready = 1'b0;
    for (int s = 0; s < 6; s++) begin
      req_valid     = 6'b000010;
      req_update[1] = mk(1, s);
      cyc();
      chk("t3_drop_pulse", 64'(drop_pulse), (s == 5) ? 64'(2) : 64'(0));
    end
    req_valid = '0;
    chk("t3_drop_count", 64'(drop_count), 64'(1));
    cyc();
    chk("t3_pulse_once", 64'(drop_pulse), 64'(0));
    chk("t3_hold_src",   64'(out_src),    64'(1));
    chk("t3_hold_upd",   64'(out_update), 64'(mk(1, 0)));
    for (int s = 0; s < 5; s++) push(1, mk(1, s));
    out_ready = 1'b1;
    drain("t3_drained", 20);
    chk("t3_drop_final", 64'(drop_count), 64'(1));

    // Stall with sources 0,2,4 pending; last grant was source 1
    out_ready = 1'b0;
    req_valid = 6'b010101;
    for (int i = 0; i < 6; i++) req_update[i] = mk(i, 7);
    cyc();
    req_valid = '0;
    cyc();
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("t4_stall_valid", 64'(out_valid),  64'(1));
      chk("t4_stall_src",   64'(out_src),    64'(2));
      chk("t4_stall_upd",   64'(out_update), 64'(mk(2, 7)));
    end
    push(2, mk(2, 7));
    push(4, mk(4, 7));
    push(0, mk(0, 7));
    out_ready = 1'b1;
    drain("t4_drained", 10);

    // FIFO 2 full and popped while a new update arrives on it
    do_reset();
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      req_valid     = 6'b000100;
      req_update[2] = mk(2, s);
      cyc();
      chk("t5_fill_no_drop", 64'(drop_pulse), 64'(0));
    end
    for (int s = 0; s < 6; s++) push(2, mk(2, s));
    out_ready     = 1'b1;
    req_valid     = 6'b000100;
    req_update[2] = mk(2, 5);
    cyc();
    req_valid = '0;
    chk("t5_full_deq_pulse", 64'(drop_pulse), 64'(0));
    chk("t5_full_deq_count", 64'(drop_count), 64'(0));
    drain("t5_drained", 20);

    // Drive drop_count to all-ones minus 1, then saturate
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) req_update[i] = mk(i, 0);
    req_valid = '1;
    for (int c = 0; c < 5; c++) cyc();
    chk("t6_first_drops", 64'(drop_count), 64'(5));
    chk("t6_first_pulse", 64'(drop_pulse), 64'(6'b111110));
    for (int c = 0; c < 10921; c++) cyc();
    req_valid = 6'b010101;
    cyc();
    chk("t6_preload", 64'(drop_count), 64'(16'hFFFE));
    cyc();
    chk("t6_sat_pulse", 64'(drop_pulse), 64'(6'b010101));
    chk("t6_saturate",  64'(drop_count), 64'(16'hFFFF));
    req_valid = '1;
    cyc();
    chk("t6_sat_hold",  64'(drop_count), 64'(16'hFFFF));
    chk("t6_all_pulse", 64'(drop_pulse), 64'(6'b111111));

    // Reset mid-operation with buffered entries and a held output
    do_reset();
    out_ready = 1'b0;
    for (int s = 0; s < 6; s++) begin
      req_valid     = (s < 4) ? 6'b001010 : 6'b000010;
      req_update[1] = mk(1, s);
      req_update[3] = mk(3, s);
      cyc();
    end
    req_valid = '0;
    chk("t7_pre_valid", 64'(out_valid),  64'(1));
    chk("t7_pre_pulse", 64'(drop_pulse), 64'(2));
    chk("t7_pre_count", 64'(drop_count), 64'(1));
    nRST = 1'b0;
    #1;
    chk("t7_rst_valid",  64'(out_valid),  64'(0));
    chk("t7_rst_update", 64'(out_update), 64'(0));
    chk("t7_rst_src",    64'(out_src),    64'(0));
    chk("t7_rst_pulse",  64'(drop_pulse), 64'(0));
    chk("t7_rst_count",  64'(drop_count), 64'(0));
    sb.delete();
    @(posedge CLK);
    #1;
    nRST          = 1'b1;
    out_ready     = 1'b1;
    req_valid     = 6'b100001;
    req_update[0] = mk(0, 3);
    req_update[5] = mk(5, 3);
    push(0, mk(0, 3));
    push(5, mk(5, 3));
    cyc();
    req_valid = '0;
    drain("t7_drained", 10);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("t7_no_stale", 64'(out_valid), 64'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ssu_update_arbiter.md
# ssu_update_arbiter

Funnels the six memory-dependence update sources (ldu_cq CAM, ldu_mq CAM, ldu_cq commit, stamofu_cq CAM bank 0, stamofu_cq CAM bank 1, stamofu_cq commit) into a single update stream for the store-set table stage. Sources are fire-and-forget, so each source gets a small FIFO. A round-robin arbiter drains those FIFOs into a registered valid/ready output. Overflowing updates are dropped and counted, never back-pressured.

## Interface
- REQUESTER_COUNT, 6: number of update sources. Index order: 0 ldu_cq CAM, 1 ldu_mq CAM, 2 ldu_cq commit, 3 stamofu bank0 CAM, 4 stamofu bank1 CAM, 5 stamofu commit.
- FIFO_ENTRIES, SSU_INPUT_BUFFER_ENTRIES (4): depth of each per-source FIFO. Must be a power of 2, at least 2.
- DROP_COUNT_WIDTH, 16: width of the saturating drop counter.
- CLK  in  1  clock. Single clock domain; all state updates on posedge.
- nRST  in  1  reset. Asynchronous, active-low.
- req_valid  in  [REQUESTER_COUNT]  update present this cycle, one bit per source.
- req_update  in  [REQUESTER_COUNT] x ssu_update_t  per-source update payload.
- out_valid  out  1  output register holds an update.
- out_ready  in  1  table stage accepts the update this cycle.
- out_update  out  ssu_update_t  granted payload.
- out_src  out  $clog2(REQUESTER_COUNT)  index of the originating source.
- drop_pulse  out  [REQUESTER_COUNT]  registered; bit set for one cycle after that source's update was dropped.
- drop_count  out  DROP_COUNT_WIDTH  total drops, saturating at all-ones.

## Operation
- ssu_update_t fields: is_dep (1), ld_mdp_info (MDPT_INFO_WIDTH), ld_ROB_index (LOG_ROB_ENTRIES), stamo_mdp_info (MDPT_INFO_WIDTH), stamo_ROB_index (LOG_ROB_ENTRIES).
- Commit sources (2, 5) drive is_dep=0 and carry the committing instruction in the ld_* fields. The stamo_* fields are forwarded untouched and must not be interpreted.
- Enqueue: req_valid[i] writes FIFO i at the edge if count_i < FIFO_ENTRIES, or if FIFO i is dequeued in the same cycle (full plus simultaneous dequeue accepts). Otherwise the update is dropped: drop_pulse[i] is set next cycle and drop_count increments.
- Multiple drops in one cycle add popcount(drops) to drop_count, saturating.
- Output load condition: the output register loads when it is free, i.e. ~out_valid | out_ready.
- Grant: when the output register loads, grant the first non-empty FIFO searching from rr_ptr+1 upward with wrap. The granted FIFO is popped and rr_ptr is set to the granted index.
- No grant when all FIFOs are empty. In that case out_valid clears if the output register was consumed.
- Arbitration sees only FIFO heads from the current cycle. An update enqueued this cycle is not eligible until the next cycle; there is no bypass.
- out_valid & ~out_ready: out_update and out_src are held stable and rr_ptr is unchanged.
- Reset values (async, immediate): all FIFOs empty, rr_ptr = REQUESTER_COUNT-1 (source 0 has first priority), out_valid=0, out_update=0, out_src=0, drop_pulse=0, drop_count=0.
- Reset mid-operation discards all buffered and in-flight updates.

## Timing
- Latency: req_valid in cycle N gives out_valid in cycle N+2 when the block is idle with out_ready=1.
- Throughput: 1 update per cycle while any FIFO is non-empty and out_ready=1.
- Fairness: with all sources backlogged, each source is granted exactly once in every REQUESTER_COUNT consecutive grants.
- FIFO pointers are log2(FIFO_ENTRIES) bits and wrap naturally. Count is log2(FIFO_ENTRIES)+1 bits.
- drop_count never wraps; it holds at all-ones.

## Structure
- core_types_pkg gets ssu_update_t, SSU_UPDATE_REQUESTERS=6, and the source index constants SSU_SRC_LDU_CQ_CAM through SSU_SRC_STAMOFU_CQ_COMMIT.
- Sub-module ssu_update_fifo: parameterized single-source FIFO with enq/deq/full/empty/head, instantiated REQUESTER_COUNT times.
- Round-robin search and the output register live in the top level.

## Test plan
- Single update on source 3 in cycle 0 with out_ready=1 → out_valid in cycle 2, out_src=3, payload bit-exact, then out_valid=0 in cycle 3.
- All six sources pulse every cycle for 20 cycles with out_ready=1 → grant order 0,1,2,3,4,5,0,…. FIFOs fill and drops begin; drop_count equals 120 minus (updates granted + updates still buffered).
- Source 1 sends 6 back-to-back updates with out_ready=0 → first 4 buffered, plus 1 held in the output register after the first grant; the 6th is dropped, drop_pulse[1] fires once, drop_count=1.
- Output stalled with out_ready=0 for 5 cycles → out_update and out_src stable throughout and rr_ptr unchanged. On release, the next grant is the first non-empty source after the held one.
- FIFO 2 full while being dequeued, with req_valid[2]=1 in the same cycle → update accepted with no drop, and FIFO order is preserved.
- Preload drop_count to all-ones minus 1, then force 3 simultaneous drops → drop_count saturates at all-ones.
- Assert nRST while FIFOs hold 3 entries and out_valid=1 → all outputs are immediately at reset values. After release, the first grant goes to source 0 if sources 0 and 5 both enqueue.
